fetch_sequencer: RTL and testbench

- Control stage directly upstream of the ALU system datapath.
- Drives the ARF, Memory and IR control inputs to fetch each 16-bit instruction as two bytes at PC, low byte first.
- Hands the fetched instruction to the execute/decode controller through a valid/done handshake.
- Loops fetch -> wait-for-execute until halted.

---
 rtl/fetch_sequencer.sv | 61 ++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 16-bit instructions as two PC-addressed bytes and hands them to execute
module fetch_sequencer #(
    parameter logic [1:0] PC_OUTD_SEL = 2'b00,
    parameter logic [2:0] ARF_INC     = 3'b001,
    parameter logic [2:0] ARF_PC_EN   = 3'b100,
    parameter int         CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             ExecDone,
    input  logic             Halt,
    output logic [1:0]       ARF_OutDSel,
    output logic [2:0]       ARF_FunSel,
    output logic [2:0]       ARF_RegSel,
    output logic             Mem_CS,
    output logic             Mem_WR,
    output logic             IR_Write,
    output logic             IR_LH,
    output logic             InstrValid,
    output logic             Busy,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] InstrCount
);
    typedef enum logic [1:0] {IDLE = 2'b00, FETCH_L = 2'b01, FETCH_H = 2'b10, WAIT_EXEC = 2'b11} state_t;
    state_t st;
    logic fetching;
    // Sequence IDLE -> low byte -> high byte -> wait for execute, counting completed fetches
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            st <= IDLE;
            InstrCount <= '0;
        end else begin
            case (st)
                IDLE:      if (Start) st <= FETCH_L;
                FETCH_L:   if (!Stall) st <= FETCH_H;
                FETCH_H:   if (!Stall) begin
                    st <= WAIT_EXEC;
                    InstrCount <= InstrCount + CNT_W'(1);
                end
                WAIT_EXEC: if (ExecDone) st <= Halt ? IDLE : FETCH_L;
                default:   st <= IDLE;
            endcase
        end
    end
    // Decode datapath controls from state and Stall; a low Reset forces idle values so no write lands on the reset edge
    always_comb begin
        fetching    = Reset && (st == FETCH_L || st == FETCH_H) && !Stall;
        Mem_CS      = !fetching;
        Mem_WR      = 1'b0;
        IR_Write    = fetching;
        IR_LH       = Reset && st == FETCH_H;
        ARF_RegSel  = fetching ? ARF_PC_EN : 3'b000;
        ARF_FunSel  = ARF_INC;
        ARF_OutDSel = PC_OUTD_SEL;
        InstrValid  = Reset && st == WAIT_EXEC;
        Busy        = Reset && st != IDLE;
        State       = st;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: drives the sequencer against a small PC/memory/IR model and scoreboards fetched instructions
module tb_fetch_sequencer;
    logic Clock, Reset, Start, Stall, ExecDone, Halt;
    logic [1:0] ARF_OutDSel, State, State4, OutDSel4;
    logic [2:0] ARF_FunSel, ARF_RegSel, FunSel4, RegSel4;
    logic Mem_CS, Mem_WR, IR_Write, IR_LH, InstrValid, Busy;
    logic CS4, WR4, IRW4, IRLH4, Valid4, Busy4;
    logic [15:0] InstrCount;
    logic [3:0] Count4;
    logic [13:0] ctl, ctl4;

    fetch_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stall(Stall), .ExecDone(ExecDone), .Halt(Halt),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_Write(IR_Write), .IR_LH(IR_LH),
        .InstrValid(InstrValid), .Busy(Busy), .State(State), .InstrCount(InstrCount)
    );

    fetch_sequencer #(.CNT_W(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stall(Stall), .ExecDone(ExecDone), .Halt(Halt),
        .ARF_OutDSel(OutDSel4), .ARF_FunSel(FunSel4), .ARF_RegSel(RegSel4),
        .Mem_CS(CS4), .Mem_WR(WR4), .IR_Write(IRW4), .IR_LH(IRLH4),
        .InstrValid(Valid4), .Busy(Busy4), .State(State4), .InstrCount(Count4)
    );

    assign ctl  = {IR_Write, IR_LH, ARF_RegSel, ARF_FunSel, ARF_OutDSel, Mem_CS, Mem_WR, InstrValid, Busy};
    assign ctl4 = {IRW4, IRLH4, RegSel4, FunSel4, OutDSel4, CS4, WR4, Valid4, Busy4};

    localparam logic [13:0] RST_CTL = {1'b0, 1'b0, 3'b000, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] FL_CTL  = {1'b1, 1'b0, 3'b100, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [13:0] FH_CTL  = {1'b1, 1'b1, 3'b100, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [13:0] WE_CTL  = {1'b0, 1'b0, 3'b000, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};

    // datapath model: ARF PC, byte memory, IR
    logic [7:0] mem [0:255];
    logic [15:0] pc, ir, env_pc;
    logic env_load;
    logic [7:0] mem_out;
    assign mem_out = mem[pc[7:0]];

    always @(posedge Clock) begin
        if (env_load) pc <= env_pc;
        else if (ARF_RegSel == 3'b100 && ARF_FunSel == 3'b001) pc <= pc + 16'd1;
        if (IR_Write && !Mem_CS && !Mem_WR && ARF_OutDSel == 2'b00) begin
            if (IR_LH) ir[15:8] <= mem_out;
            else ir[7:0] <= mem_out;
        end
    end

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {logic [15:0] ir; logic [15:0] pc; logic [15:0] cnt;} exp_t;
    exp_t q[$];
    exp_t e;
    int vec = 0;
    int miss = 0;

    task automatic cyc;
        @(negedge Clock);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            cyc;
            ok = InstrValid;
        end
    endtask

    task automatic test_reset;
        Reset = 0; Start = 0; Stall = 0; ExecDone = 0; Halt = 0;
        env_load = 1; env_pc = 16'h0000;
        cyc; cyc;
        vec++; if (State !== 2'b00 || InstrCount !== 16'd0) begin miss++; $display("FAIL reset_state: state=%b cnt=%h exp 00/0000", State, InstrCount); end
        vec++; if (ctl !== RST_CTL) begin miss++; $display("FAIL reset_ctl: got %b exp %b", ctl, RST_CTL); end
        vec++; if (ctl4 !== RST_CTL || State4 !== 2'b00 || Count4 !== 4'd0) begin miss++; $display("FAIL reset_ctl4: got %b/%b/%h", ctl4, State4, Count4); end
        Reset = 1; env_load = 0;
        cyc;
        vec++; if (State !== 2'b00 || ctl !== RST_CTL) begin miss++; $display("FAIL idle_hold: state=%b ctl=%b", State, ctl); end
    endtask

    task automatic test_basic;
        q.push_back('{16'h1234, 16'h0002, 16'd1});
        Start = 1;
        cyc; Start = 0;
        vec++; if (State !== 2'b01 || ctl !== FL_CTL) begin miss++; $display("FAIL basic_fetch_l: state=%b ctl=%b exp 01/%b", State, ctl, FL_CTL); end
        cyc;
        vec++; if (State !== 2'b10 || ctl !== FH_CTL) begin miss++; $display("FAIL basic_fetch_h: state=%b ctl=%b exp 10/%b", State, ctl, FH_CTL); end
        cyc;
        vec++; if (State !== 2'b11 || ctl !== WE_CTL) begin miss++; $display("FAIL basic_valid_cycle3: state=%b ctl=%b exp 11/%b", State, ctl, WE_CTL); end
        e = q.pop_front();
        vec++; if ({ir, pc, InstrCount} !== e) begin miss++; $display("FAIL basic_result: ir=%h pc=%h cnt=%h exp %h %h %h", ir, pc, InstrCount, e.ir, e.pc, e.cnt); end
    endtask

    task automatic test_back_to_back;
        q.push_back('{16'hABCD, 16'h0004, 16'd2});
        ExecDone = 1; Halt = 0;
        cyc; ExecDone = 0;
        vec++; if (InstrValid !== 1'b0 || State !== 2'b01) begin miss++; $display("FAIL b2b_drop1: valid=%b state=%b exp 0/01", InstrValid, State); end
        cyc;
        vec++; if (InstrValid !== 1'b0) begin miss++; $display("FAIL b2b_drop2: valid=%b exp 0", InstrValid); end
        cyc;
        vec++; if (InstrValid !== 1'b1) begin miss++; $display("FAIL b2b_return: valid=%b exp 1", InstrValid); end
        e = q.pop_front();
        vec++; if ({ir, pc, InstrCount} !== e) begin miss++; $display("FAIL b2b_result: ir=%h pc=%h cnt=%h exp %h %h %h", ir, pc, InstrCount, e.ir, e.pc, e.cnt); end
    endtask

    task automatic test_halt;
        bit ok;
        ExecDone = 1; Halt = 1;
        cyc; Halt = 0;
        vec++; if (State !== 2'b00 || Busy !== 1'b0) begin miss++; $display("FAIL halt_idle: state=%b busy=%b exp 00/0", State, Busy); end
        cyc; ExecDone = 0;
        vec++; if (State !== 2'b00) begin miss++; $display("FAIL execdone_in_idle: state=%b exp 00", State); end
        q.push_back('{16'h5678, 16'h0006, 16'd3});
        Start = 1;
        cyc; Start = 0;
        vec++; if (State !== 2'b01 || pc !== 16'h0004) begin miss++; $display("FAIL resume_pc: state=%b pc=%h exp 01/0004", State, pc); end
        wait_valid(ok);
        vec++; if (!ok) begin miss++; $display("FAIL resume_timeout: valid=%b exp 1", InstrValid); end
        e = q.pop_front();
        vec++; if ({ir, pc, InstrCount} !== e) begin miss++; $display("FAIL resume_result: ir=%h pc=%h cnt=%h exp %h %h %h", ir, pc, InstrCount, e.ir, e.pc, e.cnt); end
        Start = 1;
        cyc; cyc; Start = 0;
        vec++; if (State !== 2'b11) begin miss++; $display("FAIL start_in_wait: state=%b exp 11", State); end
        ExecDone = 1; Halt = 1;
        cyc; ExecDone = 0; Halt = 0;
    endtask

    task automatic test_stall;
        bit ok;
        logic [7:0] hi;
        env_load = 1; env_pc = 16'h0000;
        cyc; env_load = 0;
        q.push_back('{16'h1234, 16'h0002, 16'd4});
        Start = 1;
        cyc; Start = 0;
        cyc;
        hi = ir[15:8];
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++; if ({IR_Write, ARF_RegSel, Mem_CS} !== 5'b0_000_1) begin miss++; $display("FAIL stall_ctl[%0d]: irw=%b regsel=%b cs=%b exp 0/000/1", i, IR_Write, ARF_RegSel, Mem_CS); end
            cyc;
            vec++; if (State !== 2'b10 || pc !== 16'h0001 || ir[15:8] !== hi) begin miss++; $display("FAIL stall_hold[%0d]: state=%b pc=%h irh=%h exp 10/0001/%h", i, State, pc, ir[15:8], hi); end
        end
        Stall = 0;
        wait_valid(ok);
        vec++; if (!ok) begin miss++; $display("FAIL stall_timeout: valid=%b exp 1", InstrValid); end
        e = q.pop_front();
        vec++; if ({ir, pc, InstrCount} !== e) begin miss++; $display("FAIL stall_result: ir=%h pc=%h cnt=%h exp %h %h %h", ir, pc, InstrCount, e.ir, e.pc, e.cnt); end
        ExecDone = 1; Halt = 1;
        cyc; ExecDone = 0; Halt = 0;
    endtask

    task automatic test_reset_mid;
        logic [15:0] sir, spc;
        Start = 1;
        cyc; Start = 0;
        cyc;
        vec++; if (State !== 2'b10) begin miss++; $display("FAIL mid_setup: state=%b exp 10", State); end
        sir = ir; spc = pc;
        Reset = 0;
        #1;
        vec++; if (IR_Write !== 1'b0 || ctl !== RST_CTL) begin miss++; $display("FAIL mid_gate: ctl=%b exp %b", ctl, RST_CTL); end
        cyc;
        vec++; if (State !== 2'b00 || InstrCount !== 16'd0 || Count4 !== 4'd0) begin miss++; $display("FAIL mid_reset: state=%b cnt=%h cnt4=%h exp 00/0/0", State, InstrCount, Count4); end
        vec++; if (ir !== sir || pc !== spc) begin miss++; $display("FAIL mid_no_write: ir=%h pc=%h exp %h %h", ir, pc, sir, spc); end
        Reset = 1;
        #1;
        vec++; if (ctl !== RST_CTL) begin miss++; $display("FAIL mid_idle_ctl: ctl=%b exp %b", ctl, RST_CTL); end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [15:0] ep;
        logic [7:0] a0, a1;
        ep = pc;
        Start = 1;
        cyc; Start = 0;
        for (int i = 0; i < 16; i++) begin
            a0 = ep[7:0]; a1 = a0 + 8'd1;
            q.push_back('{{mem[a1], mem[a0]}, ep + 16'd2, 16'(i + 1)});
            ep = ep + 16'd2;
            wait_valid(ok);
            vec++; if (!ok) begin miss++; $display("FAIL wrap_timeout[%0d]: valid=%b exp 1", i, InstrValid); end
            e = q.pop_front();
            vec++; if ({ir, pc, InstrCount} !== e) begin miss++; $display("FAIL wrap_result[%0d]: ir=%h pc=%h cnt=%h exp %h %h %h", i, ir, pc, InstrCount, e.ir, e.pc, e.cnt); end
            vec++; if (Count4 !== 4'(i + 1)) begin miss++; $display("FAIL wrap_cnt4[%0d]: got %h exp %h", i, Count4, 4'(i + 1)); end
            if (i == 0) begin
                Start = 1;
                cyc; Start = 0;
                vec++; if (State !== 2'b11 || State4 !== 2'b11) begin miss++; $display("FAIL wrap_start_ignored: state=%b exp 11", State); end
            end
            ExecDone = 1; Halt = (i == 15);
            cyc; ExecDone = 0; Halt = 0;
        end
        vec++; if (State !== 2'b00 || Count4 !== 4'd0 || InstrCount !== 16'd16) begin miss++; $display("FAIL wrap_end: state=%b cnt4=%h cnt=%h exp 00/0/0010", State, Count4, InstrCount); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'hCD; mem[3] = 8'hAB; mem[4] = 8'h78; mem[5] = 8'h56;
        test_reset;
        test_basic;
        test_back_to_back;
        test_halt;
        test_stall;
        test_reset_mid;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
